// File: rtl/avalon_burst_ram_agent.sv
// Avalon-MM burst agent backed by on-chip RAM: burst writes, pipelined burst reads.
// Optional protocol checker (sticky proto_err output) enabled by AVALON_AGENT_PROTOCHK_EN.
module avalon_burst_ram_agent #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int BURST_WIDTH  = 5,
    parameter int READ_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     writedata,
    input  logic [BURST_WIDTH-1:0]    burstcount,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      waitrequest,
    output logic                      readdatavalid
`ifdef AVALON_AGENT_PROTOCHK_EN
    ,
    output logic                      proto_err
`endif
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [BURST_WIDTH-1:0]   remaining_q, remaining_d;
    logic [BURST_WIDTH-1:0]   bc_eff;
    logic                     accept;
    logic                     rd_issue;
    logic                     mem_we;
    logic [ADDR_WIDTH-1:0]    mem_waddr;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic [READ_LATENCY:1]    vld_pipe_q;
    logic [DATA_WIDTH-1:0]    rdata_pipe_q [READ_LATENCY:1];

    assign waitrequest = reset || (state_q == RBURST);
    assign accept      = (read || write) && !waitrequest;
    assign bc_eff      = (burstcount == '0) ? BURST_WIDTH'(1) : burstcount;
    assign rd_issue    = (state_q == RBURST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        mem_we      = 1'b0;
        mem_waddr   = addr_q;
        case (state_q)
            IDLE: begin
                // write has priority; a simultaneous read is simply not taken
                if (accept && write) begin
                    mem_we    = 1'b1;
                    mem_waddr = address;
                    if (bc_eff > BURST_WIDTH'(1)) begin
                        remaining_d = bc_eff - BURST_WIDTH'(1);
                        addr_d      = address + ADDR_WIDTH'(1);
                        state_d     = WBURST;
                    end
                end else if (accept && read) begin
                    remaining_d = bc_eff;
                    addr_d      = address;
                    state_d     = RBURST;
                end
            end
            WBURST: begin
                if (write) begin
                    mem_we      = 1'b1;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - BURST_WIDTH'(1);
                    if (remaining_q == BURST_WIDTH'(1)) state_d = IDLE;
                end
            end
            RBURST: begin
                addr_d      = addr_q + ADDR_WIDTH'(1);
                remaining_d = remaining_q - BURST_WIDTH'(1);
                if (remaining_q == BURST_WIDTH'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM is deliberately left out of reset so contents survive a mid-burst reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (byteenable[b]) mem[mem_waddr][b*8 +: 8] <= writedata[b*8 +: 8];
            end
        end
    end

    // Data is captured at issue so a write following the burst cannot alter it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q <= '0;
            for (int i = 1; i <= READ_LATENCY; i++) rdata_pipe_q[i] <= '0;
        end else begin
            vld_pipe_q[1] <= rd_issue;
            if (rd_issue) rdata_pipe_q[1] <= mem[addr_q];
            for (int i = 2; i <= READ_LATENCY; i++) begin
                vld_pipe_q[i]   <= vld_pipe_q[i-1];
                rdata_pipe_q[i] <= rdata_pipe_q[i-1];
            end
        end
    end

    assign readdatavalid = vld_pipe_q[READ_LATENCY];
    assign readdata      = rdata_pipe_q[READ_LATENCY];

`ifdef AVALON_AGENT_PROTOCHK_EN
    logic proto_err_q;
    logic proto_hit;

    assign proto_hit = ((state_q == IDLE) && read && write && !reset)
                    || ((state_q == WBURST) && read)
                    || (accept && (burstcount == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          proto_err_q <= 1'b0;
        else if (proto_hit) proto_err_q <= 1'b1;
    end

    assign proto_err = proto_err_q;
`endif

endmodule
